// File: rtl/timer_unit.sv
// timer_unit: periodic interval timer with prescaler and interrupt request.
//   A load strobe (we_t) latches base/umbral from cfg and restarts the timer.
//   In RUN a 7-bit prescaler produces a tick every 2^base cycles; each tick
//   advances a 6-bit count that auto-reloads at umbral-1 and raises int_req.
//   A match while a request is still pending (and not being acked) sets ovf.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   we_t     in   one-cycle load strobe
//   cfg      in   [9]=enable, [8:6]=base, [5:0]=umbral (threshold)
//   int_ack  in   interrupt acknowledge pulse
//   int_req  out  level interrupt request, held until ack or load
//   ovf      out  sticky overrun flag
//   count    out  current tick count
//   running  out  high while in RUN
module timer_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_t,
  input  logic [9:0] cfg,
  input  logic       int_ack,
  output logic       int_req,
  output logic       ovf,
  output logic [5:0] count,
  output logic       running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] base_q, base_d;
  logic [5:0] umbral_q, umbral_d;
  logic [6:0] presc_q, presc_d;
  logic [5:0] count_q, count_d;
  logic       int_req_q, int_req_d;
  logic       ovf_q, ovf_d;

  logic [6:0] presc_top;
  logic       tick;
  logic       match;

  // Terminal prescaler value 2^base - 1 (0 for base=0, 127 for base=7).
  assign presc_top = 7'((8'd1 << base_q) - 8'd1);
  assign tick      = (state_q == RUN) && (presc_q == presc_top);
  assign match     = tick && (count_q == (umbral_q - 6'd1));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    umbral_d  = umbral_q;
    presc_d   = presc_q;
    count_d   = count_q;
    int_req_d = int_req_q;
    ovf_d     = ovf_q;

    if (we_t) begin
      // Load wins over ack and over a coincident match.
      base_d    = cfg[8:6];
      umbral_d  = cfg[5:0];
      presc_d   = '0;
      count_d   = '0;
      int_req_d = 1'b0;
      ovf_d     = 1'b0;
      state_d   = (cfg[9] && (cfg[5:0] != '0)) ? RUN : IDLE;
    end else begin
      if (state_q == RUN) begin
        presc_d = tick ? '0 : presc_q + 7'd1;
        if (tick) begin
          count_d = match ? '0 : count_q + 6'd1;
        end
      end else begin
        presc_d = '0;
        count_d = '0;
      end

      if (match) begin
        // An ack in the match cycle consumes the old request, so no overrun.
        if (int_req_q && !int_ack) begin
          ovf_d = 1'b1;
        end
        int_req_d = 1'b1;
      end else if (int_ack) begin
        int_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      umbral_q  <= '0;
      presc_q   <= '0;
      count_q   <= '0;
      int_req_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      umbral_q  <= umbral_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      int_req_q <= int_req_d;
      ovf_q     <= ovf_d;
    end
  end

  assign int_req = int_req_q;
  assign ovf     = ovf_q;
  assign count   = count_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_timer_unit.sv
// Testbench for timer_unit: each edge driven through step() pushes the
// expected {int_req, ovf, count, running} from a period-based reference
// model onto a scoreboard queue; a negedge monitor pops and compares.
// Scenario tasks add their own directed latency/sequence checks.
module tb_timer_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we_t = 1'b0;
  logic [9:0] cfg = '0;
  logic       int_ack = 1'b0;
  logic       int_req;
  logic       ovf;
  logic [5:0] count;
  logic       running;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb[$];

  // Reference model state: edges since load, configuration, flags.
  int m_k = 0, m_base = 0, m_umb = 0, m_count = 0;
  bit m_run = 0, m_req = 0, m_ovf = 0;

  timer_unit dut (
    .clk     (clk),
    .reset   (reset),
    .we_t    (we_t),
    .cfg     (cfg),
    .int_ack (int_ack),
    .int_req (int_req),
    .ovf     (ovf),
    .count   (count),
    .running (running)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [8:0] e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {int_req, ovf, count, running};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got req=%b ovf=%b cnt=%0d run=%b expected req=%b ovf=%b cnt=%0d run=%b",
                 $time, g[8], g[7], g[6:1], g[0], e[8], e[7], e[6:1], e[0]);
      end
    end
  end

  // Advance the model by one edge using the currently driven inputs, push
  // the expectation, then let the DUT take the same edge.
  task automatic step();
    int  per;
    bit  mt;
    logic [5:0] c6;
    if (!reset) begin
      m_run = 0; m_k = 0; m_count = 0; m_req = 0; m_ovf = 0; m_base = 0; m_umb = 0;
    end else if (we_t) begin
      m_base = int'(cfg[8:6]);
      m_umb  = int'(cfg[5:0]);
      m_run  = cfg[9] && (m_umb != 0);
      m_k = 0; m_count = 0; m_req = 0; m_ovf = 0;
    end else begin
      mt = 0;
      if (m_run) begin
        m_k++;
        per = 1 << m_base;
        mt = ((m_k % (m_umb * per)) == 0);
        m_count = (m_k / per) % m_umb;
      end
      if (mt) begin
        if (m_req && !int_ack) m_ovf = 1;
        m_req = 1;
      end else if (int_ack) begin
        m_req = 0;
      end
    end
    c6 = m_count[5:0];
    sb.push_back({m_req, m_ovf, c6, m_run});
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] c);
    we_t = 1'b1;
    cfg  = c;
    step();
    we_t = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++;
    if ({int_req, ovf, count, running} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got %b expected 000000000", {int_req, ovf, count, running});
    end
    // Reset beats a coincident load.
    we_t = 1'b1; cfg = 10'b1_000_000011;
    step();
    we_t = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_load running=%b expected 0", running);
    end
    reset = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_base0();
    logic [5:0] c1, c2, c3;
    int n;
    load(10'b1_000_000011);
    step(); c1 = count;
    step(); c2 = count;
    step(); c3 = count;
    checks++;
    if ({c1, c2, c3} !== {6'd1, 6'd2, 6'd0}) begin
      errors++;
      $display("FAIL base0_count_seq got %0d,%0d,%0d expected 1,2,0", c1, c2, c3);
    end
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL base0_first_match int_req=%b expected 1", int_req);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    n = 1;
    while (!int_req && n < 20) begin step(); n++; end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL base0_period got %0d edges expected 3", n);
    end
  endtask

  task automatic test_base2();
    logic [5:0] c[8];
    logic       r7, r8;
    load(10'b1_010_000010);
    for (int i = 0; i < 8; i++) begin
      step();
      c[i] = count;
      if (i == 6) r7 = int_req;
      if (i == 7) r8 = int_req;
    end
    checks++;
    if ({c[2], c[3], c[6], c[7]} !== {6'd0, 6'd1, 6'd1, 6'd0}) begin
      errors++;
      $display("FAIL base2_count got %0d,%0d,%0d,%0d expected 0,1,1,0", c[2], c[3], c[6], c[7]);
    end
    checks++;
    if ({r7, r8} !== 2'b01) begin
      errors++;
      $display("FAIL base2_latency req@7,8=%b expected 01", {r7, r8});
    end
  endtask

  task automatic test_ovf();
    load(10'b1_000_000010);
    repeat (4) step();
    checks++;
    if ({int_req, ovf} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_set got req,ovf=%b expected 11", {int_req, ovf});
    end
    load(10'b1_000_000010);
    checks++;
    if ({int_req, ovf} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear_by_load got req,ovf=%b expected 00", {int_req, ovf});
    end
  endtask

  task automatic test_ack_match();
    load(10'b1_000_000010);
    repeat (3) step();
    int_ack = 1'b1; step();          // edge 4 is a match
    checks++;
    if ({int_req, ovf} !== 2'b10) begin
      errors++;
      $display("FAIL ack_on_match got req,ovf=%b expected 10", {int_req, ovf});
    end
    step(); int_ack = 1'b0;          // edge 5, no match
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear int_req=%b expected 0", int_req);
    end
  endtask

  task automatic test_disable();
    int hits;
    load(10'b1_000_000000);
    hits = 0;
    repeat (200) begin step(); if (int_req || running || count != 0) hits++; end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL disable_umbral0 got %0d active cycles expected 0", hits);
    end
    load(10'b0_101_010101);
    hits = 0;
    repeat (200) begin step(); if (int_req || running || count != 0) hits++; end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL disable_enable0 got %0d active cycles expected 0", hits);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // Load coinciding with a match: no interrupt, new config applied.
    load(10'b1_000_000011);
    repeat (2) step();
    load(10'b1_000_000101);
    checks++;
    if ({int_req, count, running} !== {1'b0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL load_over_match got req=%b cnt=%0d run=%b expected 0,0,1", int_req, count, running);
    end
    n = 0;
    while (!int_req && n < 40) begin step(); n++; end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL reload_latency got %0d edges expected 5", n);
    end
    // Load with ack in the same cycle.
    int_ack = 1'b1;
    load(10'b1_001_000011);
    int_ack = 1'b0;
    n = 0;
    while (!int_req && n < 40) begin step(); n++; end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL load_with_ack_latency got %0d edges expected 6", n);
    end
  endtask

  task automatic test_reset_midcount();
    int hits;
    int_ack = 1'b1;
    load(10'b1_000_001010);
    int_ack = 1'b0;
    repeat (15) step();
    checks++;
    if ({int_req, count} !== {1'b1, 6'd5}) begin
      errors++;
      $display("FAIL pre_reset got req=%b cnt=%0d expected 1,5", int_req, count);
    end
    reset = 1'b0; step(); reset = 1'b1;
    checks++;
    if ({int_req, ovf, count, running} !== 9'd0) begin
      errors++;
      $display("FAIL midcount_reset got %b expected 000000000", {int_req, ovf, count, running});
    end
    hits = 0;
    repeat (30) begin step(); if (int_req || running) hits++; end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL post_reset_idle got %0d active cycles expected 0", hits);
    end
  endtask

  initial begin
    test_reset();
    test_base0();
    test_base2();
    test_ovf();
    test_ack_match();
    test_disable();
    test_back_to_back();
    test_reset_midcount();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
